// File: rtl/rr_mux_pkg.sv
// Shared types and helpers for the round-robin mux arbiter.
package rr_mux_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic [N_REQ-1:0] onehot2(input logic [SEL_W-1:0] s);
        onehot2    = '0;
        onehot2[s] = 1'b1;
    endfunction

endpackage

// File: rtl/rr_mux_arbiter_picker.sv
// Combinational round-robin picker: scans last+1, last+2, ... for the first set request.
module rr_picker
    import rr_mux_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] last,
    input  logic             exclude_en,
    input  logic [SEL_W-1:0] exclude_idx,
    output logic             any,
    output logic [SEL_W-1:0] winner
);

    logic [N_REQ-1:0] masked;
    logic [SEL_W-1:0] idx;
    logic             found;

    always_comb begin
        masked = req;
        if (exclude_en) begin
            masked[exclude_idx] = 1'b0;
        end
        // The excluded requester may still win when it is the only one asking.
        if (masked == '0) begin
            masked = req;
        end
        any    = |req;
        winner = last;
        found  = 1'b0;
        idx    = last;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = last + i[SEL_W-1:0];
            if (!found && masked[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing one 4:1 datapath among four requesters,
// with bursts of up to MAX_BURST beats per grant.
//
//   state | meaning
//   IDLE  | no grant, waiting for any request
//   GRANT | requester sel owns the datapath
module rr_mux_arbiter
    import rr_mux_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic             out_ready,
    output logic [3:0]       gnt,
    output logic [1:0]       sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [3:0]       ack
);

    state_t           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] last_q, last_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [3:0]       beat_cnt_q, beat_cnt_d;

    logic             beat;
    logic             burst_done;
    logic             rel;
    logic             pick_any;
    logic [SEL_W-1:0] pick_winner;
    logic [SEL_W-1:0] pick_last;
    logic [WIDTH-1:0] mux_data;

    assign out_valid  = (state_q == GRANT) && req[sel_q];
    assign beat       = out_valid && out_ready;
    assign burst_done = beat && (beat_cnt_q == 4'(MAX_BURST - 1));
    assign rel        = (state_q == GRANT) && (burst_done || !req[sel_q]);
    // On release the pointer moves to sel in the same cycle, so arbitrate from sel.
    assign pick_last  = (state_q == GRANT) ? sel_q : last_q;

    rr_picker u_picker (
        .req         (req),
        .last        (pick_last),
        .exclude_en  (burst_done),
        .exclude_idx (sel_q),
        .any         (pick_any),
        .winner      (pick_winner)
    );

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        last_d     = last_q;
        gnt_d      = gnt_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (pick_any) begin
                    state_d    = GRANT;
                    sel_d      = pick_winner;
                    gnt_d      = onehot2(pick_winner);
                    beat_cnt_d = '0;
                end
            end
            GRANT: begin
                if (rel) begin
                    last_d     = sel_q;
                    beat_cnt_d = '0;
                    if (pick_any) begin
                        sel_d = pick_winner;
                        gnt_d = onehot2(pick_winner);
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end else if (beat) begin
                    beat_cnt_d = beat_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            last_q     <= 2'd3;
            gnt_q      <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            last_q     <= last_d;
            gnt_q      <= gnt_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    always_comb begin
        mux_data = '0;
        case (sel_q)
            2'd0:    mux_data = a;
            2'd1:    mux_data = b;
            2'd2:    mux_data = c;
            default: mux_data = d;
        endcase
    end

    assign out_data = out_valid ? mux_data : '0;
    assign ack      = beat ? onehot2(sel_q) : '0;
    assign gnt      = gnt_q;
    assign sel      = sel_q;

endmodule
